// File: rtl/tdp_ram_pkg.sv
// Shared types and constants for the byte-write true dual-port RAM.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tdp_ram_pkg;

  // How a port's own write is reflected on its read-data output.
  typedef enum logic [1:0] {
    MODE_READFIRST,
    MODE_WRITEFIRST,
    MODE_NOCHANGE
  } mode_e;

  // Post-reset array clear, then normal operation.
  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  localparam int COLL_CNT_W = 16;

endpackage

// File: rtl/tdp_ram_port_out.sv
// Read-data path of one RAM port: mode select, valid generation, optional output register.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from request to dout_o/vld_o.
// Backpressure: none; one result per accepted request, dout_o holds between results.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_i              accepted request on this port this cycle
//   wr_i               request carries at least one byte-lane write
//   old_i              addressed word before this cycle's writes (0 if out of range)
//   merged_i           old_i with this port's written lanes substituted
//   dout_o, vld_o      read data and its one-cycle qualifier
module tdp_ram_port_out
  import tdp_ram_pkg::*;
#(
  parameter int    WIDTH   = 32,
  parameter mode_e MODE    = MODE_READFIRST,
  parameter int    OUT_REG = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] merged_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             vld_o
);

  logic             s1_vld_d, s1_vld_q;
  logic [WIDTH-1:0] s1_dat_d, s1_dat_q;

  always_comb begin
    s1_vld_d = req_i;
    s1_dat_d = old_i;
    // NOCHANGE suppresses the result of a write so the previous read stays visible.
    if (MODE == MODE_NOCHANGE && wr_i) s1_vld_d = 1'b0;
    if (MODE == MODE_WRITEFIRST && wr_i) s1_dat_d = merged_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) s1_dat_q <= s1_dat_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic             s2_vld_q;
      logic [WIDTH-1:0] s2_dat_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_dat_q <= s1_dat_q;
        end
      end

      assign dout_o = s2_dat_q;
      assign vld_o  = s2_vld_q;
    end else begin : g_noreg
      assign dout_o = s1_dat_q;
      assign vld_o  = s1_vld_q;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_bwe.sv
// Single-clock true dual-port RAM with byte-lane writes, per-port collision modes and post-reset clear.
// Latency: read data 1 cycle after request (2 with OUT_REG); init_done DEPTH cycles after reset.
// Backpressure: none; requests are ignored (not queued) while init_done is low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   init_done                ports accept requests
//   ena/enb, wea/web         request strobes and byte-lane write enables (all zero = read)
//   addra/addrb, dina/dinb   word address and write data
//   douta/doutb, vlda/vldb   read data and one-cycle qualifiers
//   coll, coll_cnt           write-write collision pulse and saturating count
module tdp_ram_bwe
  import tdp_ram_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 1024,
  parameter int               ADDR         = $clog2(DEPTH),
  parameter int               NB_COL       = WIDTH / 8,
  parameter mode_e            MODE_A       = MODE_READFIRST,
  parameter mode_e            MODE_B       = MODE_READFIRST,
  parameter int               OUT_REG      = 0,
  parameter int               CLEAR_ON_RST = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  ena,
  input  logic                  enb,
  input  logic [NB_COL-1:0]     wea,
  input  logic [NB_COL-1:0]     web,
  input  logic [ADDR-1:0]       addra,
  input  logic [ADDR-1:0]       addrb,
  input  logic [WIDTH-1:0]      dina,
  input  logic [WIDTH-1:0]      dinb,
  output logic [WIDTH-1:0]      douta,
  output logic [WIDTH-1:0]      doutb,
  output logic                  vlda,
  output logic                  vldb,
  output logic                  coll,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------- clear state machine ----------------
  state_e          state_q, state_d;
  logic [ADDR-1:0] ptr_q, ptr_d;
  logic            clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RST != 0) begin
          clr_we = !rst;
          ptr_d  = ptr_q + ADDR'(1);
          if (ptr_q == LAST_ADDR) begin
            state_d = ST_READY;
            ptr_d   = '0;
          end
        end else begin
          // No clear requested: contents are kept, just leave the clear state.
          state_d = ST_READY;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign init_done = (state_q == ST_READY);

  // ---------------- request decode ----------------
  logic             a_in, b_in;
  logic             wr_a, wr_b;
  logic [WIDTH-1:0] old_a, old_b, mrg_a, mrg_b;

  // Out-of-range addresses read as zero and never write.
  assign a_in  = ({1'b0, addra} < DEPTH_W);
  assign b_in  = ({1'b0, addrb} < DEPTH_W);
  assign wr_a  = init_done & ena & a_in & (|wea);
  assign wr_b  = init_done & enb & b_in & (|web);
  assign old_a = a_in ? mem[addra] : '0;
  assign old_b = b_in ? mem[addrb] : '0;

  always_comb begin
    mrg_a = old_a;
    mrg_b = old_b;
    for (int i = 0; i < NB_COL; i++) begin
      if (wea[i] && a_in) mrg_a[i*8 +: 8] = dina[i*8 +: 8];
      if (web[i] && b_in) mrg_b[i*8 +: 8] = dinb[i*8 +: 8];
    end
  end

  // ---------------- array write ----------------
  // Port A lanes are assigned after port B lanes, so on a same-address
  // collision the lanes both ports write take port A data.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr_q] <= CLEAR_VAL;
    end else begin
      for (int i = 0; i < NB_COL; i++) begin
        if (wr_b && web[i]) mem[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
      end
      for (int i = 0; i < NB_COL; i++) begin
        if (wr_a && wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
      end
    end
  end

  // ---------------- collision reporting ----------------
  logic                  coll_d, coll_q;
  logic [COLL_CNT_W-1:0] cnt_q;

  assign coll_d = wr_a & wr_b & (addra == addrb);

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll_d;
      if (coll_d && cnt_q != '1) cnt_q <= cnt_q + COLL_CNT_W'(1);
    end
  end

  assign coll     = coll_q;
  assign coll_cnt = cnt_q;

  // ---------------- read-data paths ----------------
  tdp_ram_port_out #(
    .WIDTH   (WIDTH),
    .MODE    (MODE_A),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (init_done & ena),
    .wr_i     (|wea),
    .old_i    (old_a),
    .merged_i (mrg_a),
    .dout_o   (douta),
    .vld_o    (vlda)
  );

  tdp_ram_port_out #(
    .WIDTH   (WIDTH),
    .MODE    (MODE_B),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (init_done & enb),
    .wr_i     (|web),
    .old_i    (old_b),
    .merged_i (mrg_b),
    .dout_o   (doutb),
    .vld_o    (vldb)
  );

endmodule

// File: tb/tb_tdp_ram_bwe.sv
// Bench for tdp_ram_bwe: three configurations share one stimulus stream.
//   u0: DEPTH 16, A READFIRST,  B WRITEFIRST, OUT_REG 0
//   u1: DEPTH 12, A WRITEFIRST, B NOCHANGE,   OUT_REG 1
//   u2: DEPTH 16, A NOCHANGE,   B READFIRST,  OUT_REG 0
module tb_tdp_ram_bwe;
  import tdp_ram_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;

  logic [ND-1:0] init_done, vlda, vldb, coll;
  logic [31:0]   douta [ND];
  logic [31:0]   doutb [ND];
  logic [15:0]   coll_cnt [ND];

  tdp_ram_bwe #(.WIDTH(32), .DEPTH(16), .MODE_A(MODE_READFIRST), .MODE_B(MODE_WRITEFIRST),
                .OUT_REG(0), .CLEAR_ON_RST(1), .CLEAR_VAL(32'hA5A5A5A5)) u0 (
    .clk(clk), .rst(rst), .init_done(init_done[0]), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb), .douta(douta[0]), .doutb(doutb[0]),
    .vlda(vlda[0]), .vldb(vldb[0]), .coll(coll[0]), .coll_cnt(coll_cnt[0]));

  tdp_ram_bwe #(.WIDTH(32), .DEPTH(12), .MODE_A(MODE_WRITEFIRST), .MODE_B(MODE_NOCHANGE),
                .OUT_REG(1), .CLEAR_ON_RST(1), .CLEAR_VAL(32'h5A5A0F0F)) u1 (
    .clk(clk), .rst(rst), .init_done(init_done[1]), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb), .douta(douta[1]), .doutb(doutb[1]),
    .vlda(vlda[1]), .vldb(vldb[1]), .coll(coll[1]), .coll_cnt(coll_cnt[1]));

  tdp_ram_bwe #(.WIDTH(32), .DEPTH(16), .MODE_A(MODE_NOCHANGE), .MODE_B(MODE_READFIRST),
                .OUT_REG(0), .CLEAR_ON_RST(1), .CLEAR_VAL(32'h3C3C3C3C)) u2 (
    .clk(clk), .rst(rst), .init_done(init_done[2]), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb), .douta(douta[2]), .doutb(doutb[2]),
    .vlda(vlda[2]), .vldb(vldb[2]), .coll(coll[2]), .coll_cnt(coll_cnt[2]));

  // ---------------- configuration lookup ----------------
  function automatic int depth_of(int d);
    return (d == 1) ? 12 : 16;
  endfunction
  function automatic logic [31:0] clrv(int d);
    return (d == 0) ? 32'hA5A5A5A5 : (d == 1) ? 32'h5A5A0F0F : 32'h3C3C3C3C;
  endfunction
  function automatic mode_e ma(int d);
    return (d == 0) ? MODE_READFIRST : (d == 1) ? MODE_WRITEFIRST : MODE_NOCHANGE;
  endfunction
  function automatic mode_e mb(int d);
    return (d == 0) ? MODE_WRITEFIRST : (d == 1) ? MODE_NOCHANGE : MODE_READFIRST;
  endfunction
  function automatic int lat_of(int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Replace the byte lanes selected by we with the corresponding lanes of din.
  function automatic logic [31:0] lanes(logic [31:0] old, logic [31:0] din, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mm [ND][16];
  int          clr_left [ND];
  int          ecnt [ND];
  logic        ecoll [ND];
  // Results in flight per port: index 0 is what the next edge makes visible.
  logic        qva [ND][2];
  logic        qvb [ND][2];
  logic [31:0] qda [ND][2];
  logic [31:0] qdb [ND][2];
  logic [31:0] eda [ND];
  logic [31:0] edb [ND];
  logic        eva [ND];
  logic        evb [ND];

  int checks;
  int errors;

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      logic        ina, inb, rva, rvb, c;
      logic [31:0] olda, oldb, rda, rdb;
      int          l;
      l = lat_of(d);
      if (rst) begin
        clr_left[d] = depth_of(d);
        ecnt[d] = 0; ecoll[d] = 1'b0;
        eda[d] = '0; edb[d] = '0; eva[d] = 1'b0; evb[d] = 1'b0;
        for (int k = 0; k < 2; k++) begin
          qva[d][k] = 1'b0; qvb[d][k] = 1'b0; qda[d][k] = '0; qdb[d][k] = '0;
        end
        // By the time any read is accepted the clear has rewritten every word.
        for (int k = 0; k < 16; k++) mm[d][k] = clrv(d);
      end else begin
        ina  = int'(addra) < depth_of(d);
        inb  = int'(addrb) < depth_of(d);
        olda = ina ? mm[d][addra] : 32'h0;
        oldb = inb ? mm[d][addrb] : 32'h0;
        rva = 1'b0; rvb = 1'b0; rda = olda; rdb = oldb; c = 1'b0;
        if (clr_left[d] == 0) begin
          if (ena) begin
            rva = !(ma(d) == MODE_NOCHANGE && wea != 0);
            if (ma(d) == MODE_WRITEFIRST && wea != 0) rda = lanes(olda, ina ? dina : olda, wea);
          end
          if (enb) begin
            rvb = !(mb(d) == MODE_NOCHANGE && web != 0);
            if (mb(d) == MODE_WRITEFIRST && web != 0) rdb = lanes(oldb, inb ? dinb : oldb, web);
          end
          c = ena && enb && ina && inb && (addra == addrb) && (wea != 0) && (web != 0);
          if (enb && inb) mm[d][addrb] = lanes(mm[d][addrb], dinb, web);
          if (ena && ina) mm[d][addra] = lanes(mm[d][addra], dina, wea);
        end else begin
          clr_left[d]--;
        end
        // Enqueue at position lat-1, then retire position 0 onto the outputs.
        qva[d][l-1] = rva; qda[d][l-1] = rda;
        qvb[d][l-1] = rvb; qdb[d][l-1] = rdb;
        eva[d] = qva[d][0]; if (qva[d][0]) eda[d] = qda[d][0];
        evb[d] = qvb[d][0]; if (qvb[d][0]) edb[d] = qdb[d][0];
        qva[d][0] = qva[d][1]; qda[d][0] = qda[d][1];
        qvb[d][0] = qvb[d][1]; qdb[d][0] = qdb[d][1];
        qva[d][1] = 1'b0; qvb[d][1] = 1'b0;
        ecoll[d] = c;
        if (c && ecnt[d] < 65535) ecnt[d]++;
      end
    end
  endtask

  // Advance one clock and compare every output of every instance with the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("init_done", d, 32'(init_done[d]), 32'(clr_left[d] == 0));
      check("douta", d, douta[d], eda[d]);
      check("vlda", d, 32'(vlda[d]), 32'(eva[d]));
      check("doutb", d, doutb[d], edb[d]);
      check("vldb", d, 32'(vldb[d]), 32'(evb[d]));
      check("coll", d, 32'(coll[d]), 32'(ecoll[d]));
      check("coll_cnt", d, 32'(coll_cnt[d]), 32'(ecnt[d]));
    end
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; addra = '0; addrb = '0;
  endtask

  task automatic rand_req();
    ena   = 1'($urandom_range(0, 1));
    enb   = 1'($urandom_range(0, 1));
    wea   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    web   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    addra = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
    addrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
    dina  = $urandom;
    dinb  = $urandom;
  endtask

  initial begin
    int first0, first1;
    checks = 0;
    errors = 0;
    dina = '0; dinb = '0;
    idle();

    // Reset state.
    rst = 1'b1;
    step();
    step();

    // Clear with requests that must be ignored; reset again at cycle 7.
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin rand_req(); step(); end
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 12) rand_req(); else idle();
      step();
      if (init_done[0] && first0 < 0) first0 = k;
      if (init_done[1] && first1 < 0) first1 = k;
    end
    check("init_lat16", 0, 32'(first0), 32'd16);
    check("init_lat12", 1, 32'(first1), 32'd12);

    // Read back the cleared array on both ports.
    for (int a = 0; a < 16; a++) begin
      idle(); ena = 1'b1; enb = 1'b1; addra = 4'(a); addrb = 4'(15 - a);
      step();
      check("clr_rd", 0, douta[0], 32'hA5A5A5A5);
    end
    idle(); step(); step();

    // Byte-lane write then cross-port read.
    ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'h11223344; step();
    wea = 4'h5; dina = 32'hFFFFFFFF; step();
    idle(); enb = 1'b1; addrb = 4'd3; step();
    check("bw_lat1", 0, doutb[0], 32'h11FF33FF);
    check("bw_lat1_vld", 0, 32'(vldb[0]), 32'd1);
    check("bw_lat2_early", 1, 32'(vldb[1]), 32'd0);
    idle(); step();
    check("bw_lat2", 1, doutb[1], 32'h11FF33FF);
    check("bw_lat2_vld", 1, 32'(vldb[1]), 32'd1);

    // Collision modes on port A.
    ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'h1; step();
    dina = 32'h2; step();
    check("readfirst", 0, douta[0], 32'h1);
    check("nochange_vld", 2, 32'(vlda[2]), 32'd0);
    check("nochange_hold", 2, douta[2], 32'h3C3C3C3C);
    idle(); step();
    check("writefirst", 1, douta[1], 32'h2);

    // Write-write collision.
    ena = 1'b1; enb = 1'b1; addra = 4'd7; addrb = 4'd7; wea = 4'b0011; web = 4'b1110;
    dina = 32'hAAAAAAAA; dinb = 32'hBBBBBBBB; step();
    for (int d = 0; d < ND; d++) begin
      check("coll_pulse", d, 32'(coll[d]), 32'd1);
      check("coll_cnt1", d, 32'(coll_cnt[d]), 32'd1);
    end
    idle(); enb = 1'b1; addrb = 4'd7; step();
    check("coll_merge", 0, doutb[0], 32'hBBBBAAAA);
    check("coll_drop", 0, 32'(coll[0]), 32'd0);

    // Cross-port read during write.
    idle(); ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'h5; step();
    enb = 1'b1; addrb = 4'd9; dina = 32'h6; step();
    check("xport_old", 0, doutb[0], 32'h5);
    ena = 1'b0; step();
    check("xport_new", 0, doutb[0], 32'h6);

    // Out-of-range on the 12-word instance.
    idle(); ena = 1'b1; enb = 1'b1; wea = 4'hF; web = 4'hF; addra = 4'd13; addrb = 4'd13;
    dina = 32'hDEADBEEF; dinb = 32'hCAFEF00D; step();
    check("oor_nocoll", 1, 32'(coll[1]), 32'd0);
    check("inrange_coll", 0, 32'(coll[0]), 32'd1);
    idle(); ena = 1'b1; addra = 4'd13; step(); step();
    check("oor_rd", 1, douta[1], 32'h0);
    check("oor_vld", 1, 32'(vlda[1]), 32'd1);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin rand_req(); step(); end

    // Counter saturation.
    ena = 1'b1; enb = 1'b1; addra = 4'd0; addrb = 4'd0; wea = 4'hF; web = 4'hF;
    dina = 32'h01234567; dinb = 32'h89ABCDEF;
    for (int k = 0; k < 65540; k++) step();
    for (int d = 0; d < ND; d++) check("coll_sat", d, 32'(coll_cnt[d]), 32'h0000FFFF);
    idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
